// File: rtl/fetch_pipe.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory read per instruction,
// and registers the fetched word, its PC and PC+4 into the IF/ID outputs for decode.
// Handles decode stalls via a one-entry skid buffer, execute redirects, and discard of
// responses that belong to a PC abandoned by a redirect.
module fetch_pipe #(
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [DWIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DWIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [DWIDTH-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [DWIDTH-1:0] imem_addr_o,
    input  logic              imem_rvalid_i,
    input  logic [DWIDTH-1:0] imem_rdata_i,
    output logic [DWIDTH-1:0] instruct_do,
    output logic [DWIDTH-1:0] pc_do,
    output logic [DWIDTH-1:0] pc_plus_do,
    output logic              valid_do
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } state_e;

    state_e            state_q;
    logic [DWIDTH-1:0] pc_q;
    logic              drop_q;
    logic [DWIDTH-1:0] skid_q;
    logic [DWIDTH-1:0] instr_q;
    logic [DWIDTH-1:0] pc_out_q;
    logic [DWIDTH-1:0] pc_plus_q;
    logic              valid_q;
    logic [DWIDTH-1:0] pc_inc;

    // PC+4 wraps naturally at the top of the address space.
    assign pc_inc = pc_q + DWIDTH'(4);

    // At most one request outstanding: only the REQ state asks memory for a word.
    assign imem_req_o  = (state_q == StReq);
    assign imem_addr_o = pc_q;

    assign instruct_do = instr_q;
    assign pc_do       = pc_out_q;
    assign pc_plus_do  = pc_plus_q;
    assign valid_do    = valid_q;

    // Fetch FSM with registered IF/ID outputs; reset > redirect > stall.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            state_q   <= StReq;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            skid_q    <= '0;
            instr_q   <= NOP_INSTR;
            pc_out_q  <= '0;
            pc_plus_q <= '0;
            valid_q   <= 1'b0;
        end else if (redirect_i) begin
            // Flush overrides a stall: whatever decode holds is on the wrong path.
            pc_q    <= {redirect_pc_i[DWIDTH-1:2], 2'b00};
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            unique case (state_q)
                StReq: begin
                    // The request going out this cycle targets the old PC.
                    drop_q  <= 1'b1;
                    state_q <= StWait;
                end
                StWait: begin
                    if (imem_rvalid_i) begin
                        drop_q  <= 1'b0;
                        state_q <= StReq;
                    end else begin
                        drop_q <= 1'b1;
                    end
                end
                StHold: begin
                    state_q <= StReq;
                end
                default: state_q <= StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    state_q <= StWait;
                    // Decode has consumed the last word; do not present it twice.
                    if (!stall_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (imem_rvalid_i && drop_q) begin
                        drop_q  <= 1'b0;
                        state_q <= StReq;
                        if (!stall_i) begin
                            instr_q <= NOP_INSTR;
                            valid_q <= 1'b0;
                        end
                    end else if (imem_rvalid_i) begin
                        if (!stall_i) begin
                            instr_q   <= imem_rdata_i;
                            pc_out_q  <= pc_q;
                            pc_plus_q <= pc_inc;
                            valid_q   <= 1'b1;
                            pc_q      <= pc_inc;
                            state_q   <= StReq;
                        end else begin
                            skid_q  <= imem_rdata_i;
                            state_q <= StHold;
                        end
                    end else if (!stall_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (!stall_i) begin
                        instr_q   <= skid_q;
                        pc_out_q  <= pc_q;
                        pc_plus_q <= pc_inc;
                        valid_q   <= 1'b1;
                        pc_q      <= pc_inc;
                        state_q   <= StReq;
                    end
                end
                default: state_q <= StReq;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe with a 1-cycle-latency instruction memory model.
module tb_fetch_pipe;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        valid;

    int checks = 0;
    int errors = 0;

    fetch_pipe #(
        .DWIDTH   (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .Clk_Core     (clk),
        .Rst_Core_N   (rst_n),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .instruct_do  (instr),
        .pc_do        (pc),
        .pc_plus_do   (pc_plus),
        .valid_do     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return 32'hA000_0000 | a;
        endcase
    endfunction

    // Memory accepts a request at the edge and answers exactly one cycle later.
    always @(posedge clk) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= req;
            rdata  <= mem_word(addr);
        end
    end

    // Step negedges until valid_do rises, bounded.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 12);
        if (!valid) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: valid_do=%0b after %0d cycles, want 1", name, valid, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        repeat (3) @(negedge clk);
        checks++; if (instr !== Nop) begin errors++; $display("FAIL rst_instr got %h want %h", instr, Nop); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc); end
        checks++; if (pc_plus !== 32'h0) begin errors++; $display("FAIL rst_pcp got %h want 0", pc_plus); end
        rst_n = 1'b1;
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin
            errors++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=0", req, addr);
        end
    endtask

    task automatic test_fetch();
        wait_valid("fetch0");
        checks++; if (instr !== 32'h0050_0093 || pc !== 32'h0 || pc_plus !== 32'h4) begin
            errors++; $display("FAIL fetch0 got %h/%h/%h want 00500093/0/4", instr, pc, pc_plus);
        end
        wait_valid("fetch4");
        checks++; if (instr !== 32'h00A0_0113 || pc !== 32'h4 || pc_plus !== 32'h8) begin
            errors++; $display("FAIL fetch4 got %h/%h/%h want 00a00113/4/8", instr, pc, pc_plus);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (req !== 1'b0 || addr !== 32'h8) begin
            errors++; $display("FAIL stall_hold_req got req=%b addr=%h want 0/8", req, addr);
        end
        checks++; if (valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h00A0_0113) begin
            errors++; $display("FAIL stall_frozen1 got %b/%h/%h want 1/4/00a00113", valid, pc, instr);
        end
        @(negedge clk);
        checks++; if (valid !== 1'b1 || pc !== 32'h4 || req !== 1'b0) begin
            errors++; $display("FAIL stall_frozen2 got %b/%h/req=%b want 1/4/0", valid, pc, req);
        end
        stall = 1'b0;
        @(negedge clk);
        checks++; if (instr !== 32'hA000_0008 || pc !== 32'h8 || pc_plus !== 32'hC || valid !== 1'b1) begin
            errors++; $display("FAIL stall_release got %h/%h/%h/%b want a0000008/8/c/1", instr, pc, pc_plus, valid);
        end
        checks++; if (req !== 1'b1 || addr !== 32'hC) begin
            errors++; $display("FAIL stall_next_req got %b/%h want 1/c", req, addr);
        end
    endtask

    task automatic test_redirect_req();
        wait_valid("fetchC");
        checks++; if (pc !== 32'hC || req !== 1'b1 || addr !== 32'h10) begin
            errors++; $display("FAIL pre_redirect got pc=%h req=%b addr=%h want c/1/10", pc, req, addr);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (valid !== 1'b0 || instr !== Nop || pc !== 32'hC) begin
            errors++; $display("FAIL redir_flush got %b/%h/%h want 0/00000013/c", valid, instr, pc);
        end
        @(negedge clk);
        checks++; if (valid !== 1'b0 || req !== 1'b1 || addr !== 32'h100) begin
            errors++; $display("FAIL redir_drop got valid=%b req=%b addr=%h want 0/1/100", valid, req, addr);
        end
        wait_valid("fetch100");
        checks++; if (instr !== 32'hA000_0100 || pc !== 32'h100 || pc_plus !== 32'h104) begin
            errors++; $display("FAIL redir_target got %h/%h/%h want a0000100/100/104", instr, pc, pc_plus);
        end
    endtask

    task automatic test_redirect_rvalid_stall();
        @(negedge clk);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL wait_state_req got %b want 0", req); end
        redirect = 1'b1; redirect_pc = 32'h0000_0201; stall = 1'b1;
        @(negedge clk);
        checks++; if (valid !== 1'b0 || instr !== Nop || pc !== 32'h100) begin
            errors++; $display("FAIL redir_stall_flush got %b/%h/%h want 0/00000013/100", valid, instr, pc);
        end
        checks++; if (req !== 1'b1 || addr !== 32'h200) begin
            errors++; $display("FAIL redir_stall_req got %b/%h want 1/200", req, addr);
        end
        redirect = 1'b0; stall = 1'b0;
        wait_valid("fetch200");
        checks++; if (instr !== 32'hA000_0200 || pc !== 32'h200) begin
            errors++; $display("FAIL redir_stall_target got %h/%h want a0000200/200", instr, pc);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        wait_valid("fetch_top");
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus !== 32'h0 || instr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap got %h/%h/%h want fffffffc/0/fffffffc", pc, pc_plus, instr);
        end
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next got %b/%h want 1/0", req, addr);
        end
    endtask

    task automatic test_reset_mid();
        wait_valid("fetch0_again");
        checks++; if (pc !== 32'h0 || instr !== 32'h0050_0093) begin
            errors++; $display("FAIL after_wrap got %h/%h want 0/00500093", pc, instr);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (valid !== 1'b0 || instr !== Nop || pc !== 32'h0 || pc_plus !== 32'h0) begin
            errors++; $display("FAIL mid_rst got %b/%h/%h/%h want 0/00000013/0/0", valid, instr, pc, pc_plus);
        end
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin
            errors++; $display("FAIL mid_rst_req got %b/%h want 1/0", req, addr);
        end
        rst_n = 1'b1;
        wait_valid("post_rst");
        checks++; if (pc !== 32'h0 || instr !== 32'h0050_0093) begin
            errors++; $display("FAIL post_rst got %h/%h want 0/00500093", pc, instr);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_req();
        test_redirect_rvalid_stall();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pipe.md
Name: fetch_pipe

Overview:
Instruction-fetch stage of the RV32IM pipeline. It sits directly upstream of the decode stage. It owns the program counter and issues one word read per instruction to instruction memory. The fetched instruction, its PC and PC+4 are registered into the IF/ID outputs that decode consumes. It also handles decode-side stalls, execute-side redirects (branch/jump), and discard of stale memory responses.

Parameters:
DWIDTH, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
Clk_Core  in  1  core clock, all state on rising edge
Rst_Core_N  in  1  synchronous active-low reset
stall_i  in  1  hazard unit: hold IF/ID outputs, do not advance
redirect_i  in  1  execute: branch/jump taken
redirect_pc_i  in  DWIDTH  target PC; bits [1:0] ignored (forced 0)
imem_req_o  out  1  read request; memory accepts it the same cycle
imem_addr_o  out  DWIDTH  read address (word aligned)
imem_rvalid_i  in  1  read data valid, at least 1 cycle after request
imem_rdata_i  in  DWIDTH  read data
instruct_do  out  DWIDTH  instruction to decode
pc_do  out  DWIDTH  PC of instruct_do
pc_plus_do  out  DWIDTH  pc_do + 4
valid_do  out  1  instruct_do is a real instruction (0 = bubble)

Behaviour:
- Reset (Rst_Core_N=0 at a clock edge) has priority over all other inputs.
  - pc_q=RESET_PC, state=REQ, drop_q=0, skid buffer cleared.
  - instruct_do=NOP_INSTR, pc_do=0, pc_plus_do=0, valid_do=0.
  - Reset mid-request drops any in-flight response; drop_q=0 is valid because memory is also reset.
- imem_req_o=1 only in state REQ; imem_addr_o=pc_q at all times. At most one request is outstanding.
- REQ: issue the request at pc_q; next state WAIT.
- WAIT, imem_rvalid_i=0:
  - stall_i=0: write bubble (instruct_do=NOP_INSTR, valid_do=0; pc_do/pc_plus_do hold).
  - stall_i=1: hold all outputs.
- WAIT, imem_rvalid_i=1 and drop_q=1: discard the data, drop_q<=0, go to REQ.
- WAIT, imem_rvalid_i=1, drop_q=0, stall_i=0:
  - instruct_do<=rdata, pc_do<=pc_q, pc_plus_do<=pc_q+4, valid_do<=1.
  - pc_q<=pc_q+4, go to REQ.
- WAIT, imem_rvalid_i=1, drop_q=0, stall_i=1: capture rdata into the skid buffer, hold outputs, go to HOLD.
- HOLD, stall_i=1: hold everything.
- HOLD, stall_i=0: present the skid buffer as the WAIT-accept case above, pc_q<=pc_q+4, go to REQ.
- Redirect (redirect_i=1) ranks below reset and above stall_i. On a redirect:
  - pc_q<={redirect_pc_i[DWIDTH-1:2],2'b00}.
  - Outputs flush to instruct_do=NOP_INSTR, valid_do=0; pc_do/pc_plus_do hold.
  - From REQ: this cycle's request is to the old PC, so drop_q<=1 and go to WAIT.
  - From WAIT with rvalid=0: drop_q<=1, stay in WAIT.
  - From WAIT with rvalid=1: discard the data, go to REQ.
  - From HOLD: discard the skid buffer, go to REQ.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency. A request issued at edge t yields valid_do at edge t+2.
- Arithmetic: pc+4 wraps modulo 2^DWIDTH (e.g. 0xFFFF_FFFC -> 0x0000_0000); no exception is raised.
- valid_do=0 outputs are always NOP_INSTR, so decode needs no extra gating.

Test Plan:
- Reset release with 1-cycle memory returning 0x00500093 at 0x0, then 0x00A00113 at 0x4 -> imem_addr_o=0x0 with req=1 on the first post-reset cycle. The first output is instruct_do=0x00500093, pc_do=0x0, pc_plus_do=0x4, valid_do=1; the next is pc_do=0x4.
- stall_i=1 for 3 cycles while the response for 0x8 arrives -> outputs frozen, state HOLD. On release, instruct_do shows the 0x8 word, pc_do=0x8, and the next request is to 0xC.
- redirect_i=1, redirect_pc_i=0x103 asserted in REQ for 0x10 -> the 0x10 response is dropped (valid_do stays 0). The next request is to 0x100, whose word appears with pc_do=0x100.
- redirect_i and imem_rvalid_i together in WAIT, with stall_i=1 -> outputs flush to NOP_INSTR/valid 0 despite the stall. The data is discarded and the next request goes to redirect_pc_i.
- pc_q=0xFFFF_FFFC, no stall -> pc_do=0xFFFF_FFFC, pc_plus_do=0x0000_0000, next request to 0x0.
- Rst_Core_N=0 for 1 cycle while a request is outstanding -> all outputs return to reset values, the next request goes to RESET_PC, and no stale instruction appears.
